// File: rtl/chain_latency_ctrl_if.sv
// Bundle of control, status and chain-array signals for the delay-chain latency sequencer.
// Handshake: start is a level request sampled on rising clk. It is accepted only when the
// sequencer is idle and sel < NCHAIN. busy reports acceptance on the following cycle, and
// done is a one-cycle completion pulse. There is no back-pressure.
interface chain_latency_ctrl_if #(
  parameter int NCHAIN = 8,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 10
);
  logic              start;
  logic [SEL_W-1:0]  sel;
  logic              abort;
  logic [NCHAIN-1:0] chain_dout;
  logic [NCHAIN-1:0] chain_din;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  latency;
  logic              timeout;
  logic              stuck;
  logic [1:0]        state_dbg;

  modport master (
    output start, sel, abort, chain_dout,
    input  chain_din, busy, done, latency, timeout, stuck, state_dbg
  );

  modport slave (
    input  start, sel, abort, chain_dout,
    output chain_din, busy, done, latency, timeout, stuck, state_dbg
  );
endinterface

// File: rtl/chain_latency_ctrl.sv
// Delay-chain latency sequencer: flushes the selected chain, launches a 0->1 step into it,
// and counts edges until the step arrives, reporting the latency or a stuck/timeout fault.
module chain_latency_ctrl #(
   parameter int NCHAIN    = 8,
   parameter int SEL_W     = 3,
   parameter int CNT_W     = 10,
   parameter int FLUSH_LEN = 160,
   parameter int TIMEOUT   = 1000
) (
   input logic                  clk,
   input logic                  rst_n,
   chain_latency_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_MEASURE, S_REPORT} state_t;

   localparam logic [SEL_W:0]   NCHAIN_W    = (SEL_W+1)'(NCHAIN);
   localparam logic [CNT_W-1:0] FLUSH_LEN_C = CNT_W'(FLUSH_LEN);
   localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   state_t            state, state_nxt;
   logic [SEL_W-1:0]  sel_q, sel_nxt;
   logic [CNT_W-1:0]  run_cnt, run_nxt, wd_cnt, wd_nxt, lat_cnt, lat_nxt;
   logic [NCHAIN-1:0] din_q, din_nxt;
   logic              busy_q, busy_nxt, done_q, done_nxt;
   logic [CNT_W-1:0]  latency_q, latency_nxt;
   logic              timeout_q, timeout_nxt, stuck_q, stuck_nxt;

   logic              dout_sel;
   logic [CNT_W-1:0]  run_inc, wd_inc, lat_inc;

   assign dout_sel = bus.chain_dout[sel_q];
   assign run_inc  = (run_cnt == CNT_MAX) ? run_cnt : run_cnt + 1'b1;
   assign wd_inc   = (wd_cnt  == CNT_MAX) ? wd_cnt  : wd_cnt  + 1'b1;
   assign lat_inc  = (lat_cnt == CNT_MAX) ? lat_cnt : lat_cnt + 1'b1;

   always_comb begin
      state_nxt   = state;
      sel_nxt     = sel_q;
      run_nxt     = run_cnt;
      wd_nxt      = wd_cnt;
      lat_nxt     = lat_cnt;
      din_nxt     = din_q;
      busy_nxt    = busy_q;
      done_nxt    = 1'b0;
      latency_nxt = latency_q;
      timeout_nxt = timeout_q;
      stuck_nxt   = stuck_q;

      case (state)
         S_IDLE: begin
            din_nxt  = '0;
            busy_nxt = 1'b0;
            if (bus.start && ({1'b0, bus.sel} < NCHAIN_W)) begin
               sel_nxt     = bus.sel;
               latency_nxt = '0;
               timeout_nxt = 1'b0;
               stuck_nxt   = 1'b0;
               run_nxt     = '0;
               wd_nxt      = '0;
               busy_nxt    = 1'b1;
               state_nxt   = S_FLUSH;
            end
         end
         S_FLUSH: begin
            din_nxt = '0;
            if (bus.abort) begin
               busy_nxt  = 1'b0;
               state_nxt = S_IDLE;
            end else begin
               wd_nxt  = wd_inc;
               run_nxt = dout_sel ? '0 : run_inc;
               // A completed low run wins over the watchdog firing on the same edge.
               if (run_nxt == FLUSH_LEN_C) begin
                  din_nxt   = NCHAIN'(1) << sel_q;
                  lat_nxt   = '0;
                  state_nxt = S_MEASURE;
               end else if (wd_nxt == TIMEOUT_C) begin
                  stuck_nxt   = 1'b1;
                  latency_nxt = '0;
                  busy_nxt    = 1'b0;
                  done_nxt    = 1'b1;
                  state_nxt   = S_REPORT;
               end
            end
         end
         S_MEASURE: begin
            if (bus.abort) begin
               din_nxt   = '0;
               busy_nxt  = 1'b0;
               state_nxt = S_IDLE;
            end else if (dout_sel) begin
               latency_nxt = lat_cnt;
               din_nxt     = '0;
               busy_nxt    = 1'b0;
               done_nxt    = 1'b1;
               state_nxt   = S_REPORT;
            end else if (lat_cnt == TIMEOUT_C) begin
               timeout_nxt = 1'b1;
               latency_nxt = TIMEOUT_C;
               din_nxt     = '0;
               busy_nxt    = 1'b0;
               done_nxt    = 1'b1;
               state_nxt   = S_REPORT;
            end else begin
               lat_nxt = lat_inc;
            end
         end
         S_REPORT: begin
            din_nxt   = '0;
            busy_nxt  = 1'b0;
            state_nxt = S_IDLE;
         end
         default: begin
            din_nxt   = '0;
            busy_nxt  = 1'b0;
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         sel_q     <= '0;
         run_cnt   <= '0;
         wd_cnt    <= '0;
         lat_cnt   <= '0;
         din_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         latency_q <= '0;
         timeout_q <= 1'b0;
         stuck_q   <= 1'b0;
      end else begin
         state     <= state_nxt;
         sel_q     <= sel_nxt;
         run_cnt   <= run_nxt;
         wd_cnt    <= wd_nxt;
         lat_cnt   <= lat_nxt;
         din_q     <= din_nxt;
         busy_q    <= busy_nxt;
         done_q    <= done_nxt;
         latency_q <= latency_nxt;
         timeout_q <= timeout_nxt;
         stuck_q   <= stuck_nxt;
      end
   end

   assign bus.chain_din = din_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.latency   = latency_q;
   assign bus.timeout   = timeout_q;
   assign bus.stuck     = stuck_q;
   assign bus.state_dbg = state;

endmodule

// File: tb/tb_chain_latency_ctrl.sv
// Bench for chain_latency_ctrl. Chain k is modelled as a D-flop shift register of depth 120+k.
// Per-chain overrides model broken, stuck-high and glitchy chain outputs.
module tb_chain_latency_ctrl;
   localparam int NCHAIN = 8;
   localparam int SEL_W  = 3;
   localparam int CNT_W  = 10;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   chain_latency_ctrl_if #(.NCHAIN(NCHAIN), .SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();
   chain_latency_ctrl_if #(.NCHAIN(6), .SEL_W(SEL_W), .CNT_W(CNT_W)) bus6 ();

   chain_latency_ctrl #(.NCHAIN(NCHAIN), .SEL_W(SEL_W), .CNT_W(CNT_W),
                        .FLUSH_LEN(160), .TIMEOUT(1000))
      dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   chain_latency_ctrl #(.NCHAIN(6), .SEL_W(SEL_W), .CNT_W(CNT_W),
                        .FLUSH_LEN(160), .TIMEOUT(1000))
      dut6 (.clk(clk), .rst_n(rst_n), .bus(bus6));

   assign bus6.chain_dout = '0;

   // chain models
   logic [127:0]      sr [NCHAIN];
   logic [NCHAIN-1:0] force_en, force_val, dout_w;

   always @(posedge clk) begin
      for (int k = 0; k < NCHAIN; k++) begin
         if (!rst_n) sr[k] <= '0;
         else        sr[k] <= {sr[k][126:0], bus.chain_din[k]};
      end
   end

   always_comb begin
      dout_w = '0;
      for (int k = 0; k < NCHAIN; k++)
         dout_w[k] = force_en[k] ? force_val[k] : sr[k][119+k];
   end
   assign bus.chain_dout = dout_w;

   // scoreboard
   int checks = 0;
   int errors = 0;
   int onehot_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // fault: 0 none, 1 dout tied 0, 2 dout tied 1, 3 glitch schedule
   typedef struct {
      int gap;
      int sel;
      int fault;
      int abort_t;
      int pulse_t;
      int exp_launch;
      int exp_done;
      int exp_done_t;
      int exp_lat;
      int exp_to;
      int exp_st;
   } vec_t;

   localparam int NVEC = 9;
   vec_t vecs [NVEC];

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // t counts rising edges after the accepting edge; sampling happens on falling edges.
   task automatic run_vec(input int idx, input vec_t v);
      int launch_t, launch_din, done_t, done_n, lat, to, st;
      string p;
      p = $sformatf("row%0d", idx);
      force_en  = '0;
      force_val = '0;
      if (v.fault == 1) begin force_en[v.sel] = 1'b1; force_val[v.sel] = 1'b0; end
      if (v.fault == 2) begin force_en[v.sel] = 1'b1; force_val[v.sel] = 1'b1; end
      if (v.fault == 3) begin force_en[v.sel] = 1'b1; force_val[v.sel] = 1'b0; end
      @(negedge clk);
      bus.start = 1'b1;
      bus.sel   = SEL_W'(v.sel);
      @(negedge clk);
      bus.start = 1'b0;
      check({p, " busy_at_accept"}, int'(bus.busy), 1);
      check({p, " latency_cleared"}, int'(bus.latency), 0);
      check({p, " timeout_cleared"}, int'(bus.timeout), 0);
      check({p, " stuck_cleared"}, int'(bus.stuck), 0);
      launch_t = -1; launch_din = 0; done_t = -1; done_n = 0;
      lat = 0; to = 0; st = 0;
      for (int t = 0; t < 1400; t++) begin
         if (t > 0) @(negedge clk);
         bus.start = 1'b0;
         bus.abort = 1'b0;
         if ($countones(bus.chain_din) > 1) onehot_bad++;
         if (bus.chain_din != '0 && launch_t < 0) begin
            launch_t   = t;
            launch_din = int'(bus.chain_din);
         end
         if (bus.done) begin
            done_n++;
            if (done_t < 0) begin
               done_t = t;
               lat = int'(bus.latency);
               to  = int'(bus.timeout);
               st  = int'(bus.stuck);
            end
         end
         if (v.fault == 3) begin
            if (t == 100) force_val[v.sel] = 1'b1;
            if (t == 105) force_val[v.sel] = 1'b0;
            if (launch_t >= 0) force_en[v.sel] = 1'b0;
         end
         if (t == v.abort_t) bus.abort = 1'b1;
         if (v.abort_t >= 0 && t == v.abort_t + 1) begin
            check({p, " abort_busy"}, int'(bus.busy), 0);
            check({p, " abort_din"}, int'(bus.chain_din), 0);
            check({p, " abort_state"}, int'(bus.state_dbg), 0);
         end
         if (t == v.pulse_t) begin
            bus.start = 1'b1;
            bus.sel   = SEL_W'(3);
         end
         if (done_t >= 0 && t == done_t + 1) break;
         if (v.abort_t >= 0 && t == v.abort_t + 100) break;
      end
      if (done_t < 0) begin
         lat = int'(bus.latency);
         to  = int'(bus.timeout);
         st  = int'(bus.stuck);
      end
      check({p, " launch_t"}, launch_t, v.exp_launch);
      if (v.exp_launch >= 0) check({p, " launch_din"}, launch_din, 1 << v.sel);
      check({p, " done_count"}, done_n, v.exp_done);
      check({p, " done_t"}, done_t, v.exp_done_t);
      check({p, " latency"}, lat, v.exp_lat);
      check({p, " timeout"}, to, v.exp_to);
      check({p, " stuck"}, st, v.exp_st);
      check({p, " end_busy"}, int'(bus.busy), 0);
      check({p, " end_state"}, int'(bus.state_dbg), 0);
      force_en = '0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      //            gap sel flt abort pulse launch done done_t lat  to st
      vecs[0] = '{150, 3, 0,  -1,   -1,  160,   1,  284,  123,  0, 0};
      vecs[1] = '{150, 5, 1,  -1,   -1,  160,   1, 1161, 1000,  1, 0};
      vecs[2] = '{150, 2, 2,  -1,   -1,   -1,   1, 1000,    0,  0, 1};
      vecs[3] = '{150, 1, 3,  -1,   -1,  265,   1,  387,  121,  0, 0};
      vecs[4] = '{150, 4, 0, 210,   -1,  160,   0,   -1,    0,  0, 0};
      vecs[5] = '{150, 6, 0,  -1,   20,  160,   1,  287,  126,  0, 0};
      vecs[6] = '{150, 0, 0,  -1,  281,  160,   1,  281,  120,  0, 0};
      vecs[7] = '{150, 0, 0,  -1,   -1,  160,   1,  281,  120,  0, 0};
      vecs[8] = '{  0, 7, 0,  -1,   -1,  160,   1,  288,  127,  0, 0};

      rst_n      = 1'b0;
      force_en   = '0;
      force_val  = '0;
      bus.start  = 1'b0;
      bus.sel    = '0;
      bus.abort  = 1'b0;
      bus6.start = 1'b0;
      bus6.sel   = '0;
      bus6.abort = 1'b0;
      idle(2);
      check("reset din", int'(bus.chain_din), 0);
      check("reset busy", int'(bus.busy), 0);
      check("reset done", int'(bus.done), 0);
      check("reset latency", int'(bus.latency), 0);
      check("reset state", int'(bus.state_dbg), 0);
      rst_n = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         idle(vecs[i].gap);
         run_vec(i, vecs[i]);
      end

      // reset from IDLE with a held result
      check("held latency", int'(bus.latency), 127);
      rst_n = 1'b0;
      idle(2);
      check("idle reset latency", int'(bus.latency), 0);
      rst_n = 1'b1;
      idle(150);

      // reset in the middle of MEASURE
      @(negedge clk);
      bus.start = 1'b1;
      bus.sel   = SEL_W'(3);
      @(negedge clk);
      bus.start = 1'b0;
      idle(200);
      check("pre_reset din", int'(bus.chain_din), 8);
      check("pre_reset busy", int'(bus.busy), 1);
      rst_n = 1'b0;
      idle(2);
      check("mid reset din", int'(bus.chain_din), 0);
      check("mid reset busy", int'(bus.busy), 0);
      check("mid reset done", int'(bus.done), 0);
      check("mid reset latency", int'(bus.latency), 0);
      check("mid reset timeout", int'(bus.timeout), 0);
      check("mid reset stuck", int'(bus.stuck), 0);
      check("mid reset state", int'(bus.state_dbg), 0);
      rst_n = 1'b1;
      idle(2);

      // out-of-range select on a 6-chain instance
      @(negedge clk);
      bus6.start = 1'b1;
      bus6.sel   = SEL_W'(7);
      @(negedge clk);
      bus6.start = 1'b0;
      check("n6 sel7 busy", int'(bus6.busy), 0);
      check("n6 sel7 state", int'(bus6.state_dbg), 0);
      bus6.start = 1'b1;
      bus6.sel   = SEL_W'(5);
      @(negedge clk);
      bus6.start = 1'b0;
      check("n6 sel5 busy", int'(bus6.busy), 1);
      check("n6 sel5 state", int'(bus6.state_dbg), 1);
      bus6.abort = 1'b1;
      @(negedge clk);
      bus6.abort = 1'b0;
      check("n6 abort busy", int'(bus6.busy), 0);

      check("onehot violations", onehot_bad, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/chain_latency_ctrl.md
Name: chain_latency_ctrl

Overview:
Measurement sequencer for the delay-chain array. It flushes one selected chain to 0, launches a 0->1 step into it, and counts clock edges until the step appears at that chain's output. It reports the latency or a fault code (stuck-high, no-arrival). It sits between the top-level I/O and the NCHAIN chain instances, and owns every chain din.

Parameters:
NCHAIN, 8, number of chains driven and observed
SEL_W, 3, width of chain select; must satisfy 2**SEL_W >= NCHAIN
CNT_W, 10, width of latency/watchdog counters
FLUSH_LEN, 160, consecutive low cycles on selected dout needed before launch; must exceed the longest chain depth
TIMEOUT, 1000, watchdog limit in cycles for both FLUSH and MEASURE; FLUSH_LEN < TIMEOUT <= 2**CNT_W-1

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising clk
start  in  1  request measurement; accepted only in IDLE with sel < NCHAIN
sel  in  SEL_W  chain index, captured when start is accepted
abort  in  1  synchronous cancel of an in-flight measurement
chain_dout  in  NCHAIN  outputs of the chains
chain_din  out  NCHAIN  registered chain inputs; at most one bit high
busy  out  1  high in FLUSH and MEASURE
done  out  1  one-cycle pulse in REPORT
latency  out  CNT_W  measured edge count; held until next accepted start
timeout  out  1  no arrival within TIMEOUT; held until next accepted start
stuck  out  1  selected dout never stayed low for FLUSH_LEN within TIMEOUT; held until next accepted start

Behaviour:
- Reset, when rst_n is sampled low: state=IDLE; chain_din=0; busy=done=timeout=stuck=0; latency=0; all counters=0. Applies identically mid-operation.
- States: IDLE, FLUSH, MEASURE, REPORT. All outputs are registered.
- IDLE:
  - Accepted start: capture sel into sel_q; clear latency, timeout and stuck; zero run_cnt and wd_cnt; go to FLUSH.
  - start with sel >= NCHAIN is ignored: stay in IDLE, no flags change.
- FLUSH: chain_din all 0. Each edge, wd_cnt increments.
  - If chain_dout[sel_q]==0, run_cnt increments; otherwise run_cnt is set to 0.
  - Launch: when run_cnt reaches FLUSH_LEN on this edge, set chain_din[sel_q]=1, set lat_cnt=0, go to MEASURE.
  - Fault: otherwise, if wd_cnt reaches TIMEOUT, set stuck=1, latency=0, go to REPORT.
  - Launch has priority over the fault if both occur on the same edge.
- MEASURE: chain_din[sel_q] held at 1. Each edge samples chain_dout[sel_q]:
  - If 1: latency <= lat_cnt, go to REPORT.
  - Else if lat_cnt == TIMEOUT: timeout=1, latency=TIMEOUT, go to REPORT.
  - Else lat_cnt increments.
  - Latency convention: a pure D-flop chain of depth N reports exactly N. The edge that raises din is edge 0; arrival is sampled at edge N+1.
- REPORT: lasts one cycle. chain_din=0, done=1, busy=0; next state is IDLE. start is ignored in REPORT.
- abort:
  - In FLUSH or MEASURE: next edge goes to IDLE, chain_din=0, no done pulse, flags/latency keep their cleared values.
  - abort has priority over launch, arrival and timeout on the same edge.
  - Ignored in IDLE and REPORT.
- start while busy is ignored. The chain under test cannot change mid-measurement.
- Counters saturate and never wrap. The TIMEOUT compare stops them before 2**CNT_W-1.
- Bits of chain_dout other than sel_q never affect behaviour.

Test Plan:
- Reset: hold rst_n low 2 cycles from a random state, mid-MEASURE included -> after the edge, chain_din=0x00, busy=0, done=0, latency=0, timeout=0, stuck=0, state IDLE.
- Nominal: chain models are D-flop shift registers, chain k depth 120+k; start with sel=3 -> busy for 160 flush cycles, then chain_din=0x08; done pulses once with latency=123, timeout=0, stuck=0; chain_din returns to 0x00.
- Broken chain: dout[5] tied 0, sel=5 -> done after 160+1001 edges, timeout=1, latency=1000, stuck=0.
- Stuck-high: dout[2] tied 1, sel=2 -> chain_din never rises; done when wd_cnt=1000, stuck=1, latency=0. A glitchy dout that goes low for 100 cycles, then high, then low for 160 cycles -> launch happens only after the 160-cycle run.
- Abort/ignore: abort at cycle 50 of MEASURE -> IDLE next edge, chain_din=0x00, no done. Then start during busy, start with sel=7 on NCHAIN=6, and start during REPORT -> each ignored with no state change.
- Back-to-back: start on sel=0 then sel=7 immediately after the done pulse -> second run clears the previous latency at accept and reports depth 127; only one chain_din bit is ever high.
